tone_decoder: RTL and testbench
===============================

// Module: tone_decoder
// PURPOSE
//  Receive-side counterpart of the piano tone generator: measures the period of an incoming
//  square wave (buzzer loop-back or external pin) and decodes it to the key/flat/octave code
//  used by the piano (7-bit one-hot key, flat bit, octave bit). Output feeds the FND driver.
//  Covers C4..B5: 12 semitones x 2 octaves; flats reported as flat of the natural above.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency; period table derived from it at elaboration
//  CNT_W      20          period counter width; must hold TIMEOUT
//  TOL_SHIFT  6           match window = table_period +/- (table_period >> TOL_SHIFT)
//  STABLE_N   3           consecutive identical matches required to lock or change note
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous active-low reset
//  tone_in      in   1  asynchronous square-wave input
//  note_valid   out  1  1 = locked onto a recognised note
//  note_sel     out  7  one-hot key: bit0=C,1=D,2=E,3=F,4=G,5=A,6=B
//  note_flat    out  1  1 = flat of note_sel (Db,Eb,Gb,Ab,Bb)
//  note_octave  out  1  0 = octave 4, 1 = octave 5
//  note_change  out  1  one-cycle pulse when a new note is committed to outputs
// BEHAVIOUR
//  Reset: all outputs 0; counter 0, FSM IDLE, stable count 0, candidate cleared.
//  Input: 2-FF synchroniser, rising-edge detect on synchronised signal (2-3 cycle latency).
//  Period counter: increments every clk, saturates at TIMEOUT = 2 x period(C4); cleared on
//   each rising edge after its value is latched as the measured period.
//  FSM states IDLE, ACQUIRE, LOCKED:
//   IDLE: first rising edge only starts counting (no period measured) -> ACQUIRE.
//   ACQUIRE: each edge compares period vs 24 windows. Match equal to candidate: count++;
//    else candidate=new match, count=1; no match: count=0. count==STABLE_N -> commit, LOCKED.
//   LOCKED: outputs hold. Different note matched STABLE_N times in a row -> commit new note,
//    pulse note_change. Unmatched or same-note periods only reset the change candidate.
//   Any state: counter reaches TIMEOUT -> note_valid=0, other outputs hold, -> IDLE.
//  Commit: outputs update and note_change=1 in the same cycle, one cycle after the deciding
//   edge; note_valid rises with the first commit.
//  Windows are disjoint by construction (semitone spacing ~6% > 2 x 1.6%); with a smaller
//   TOL_SHIFT, lowest table index wins. Edge coincident with TIMEOUT: edge wins, period = TIMEOUT.
//  Reset mid-operation: immediate return to reset values; no note_change pulse.
// CONFIGURATION
//  TONE_DEC_PERIOD_OUT_EN defined: adds output period_out [CNT_W-1:0] = last measured
//   period (reset 0, updated on every rising edge). Undefined: port and register absent;
//   decode behaviour identical.
// STRUCTURE
//  Package tone_pkg: note index typedef (0..11), base-octave frequency table in centi-Hz,
//   function period_of(CLK_HZ, idx, octave), sel/flat encoding table for the 12 semitones.
//  Sub-module tone_period_match: combinational 24-window comparator, period -> hit + index.
//  Top holds synchroniser, counter, FSM, output registers.
// TESTING (bench CLK_HZ=1_000_000, TOL_SHIFT=6, STABLE_N=3)
//  440 Hz (2273 cyc) -> after 4th edge: valid=1, sel=0100000, flat=0, oct=0, change pulse 1x.
//  466.16 Hz (2145 cyc) -> sel=1000000, flat=1, oct=0; then 880 Hz -> sel=0100000, oct=1,
//   exactly one change pulse per committed note.
//  302 Hz (3311 cyc, between D4/Eb4 windows) -> valid stays 0; inserted into lock -> hold.
//  Input stops high while LOCKED -> valid=0 exactly 7644 cycles after last edge; outputs hold.
//  Alternating A4/C5 every 2 periods -> no commit from ACQUIRE, no change once LOCKED.
//  rst low mid-LOCKED -> all outputs 0 immediately; relock after STABLE_N+1 edges.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types, note tables and period arithmetic for the tone decoder.
// Window index layout: idx = octave * 12 + semitone, semitone 0 = C .. 11 = B.
package tone_pkg;

    typedef logic [3:0] note_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [6:0] sel;
        logic       flat;
    } key_code_t;

    localparam int unsigned NOTES_PER_OCT = 12;
    localparam int unsigned NUM_WIN       = 24;
    localparam int unsigned WIN_IDX_W     = 5;

    // Octave-4 equal-temperament frequencies in centi-Hz, C4 .. B4
    localparam int unsigned BASE_CHZ [NOTES_PER_OCT] = '{
        32'd26163, 32'd27718, 32'd29366, 32'd31113,
        32'd32963, 32'd34923, 32'd36999, 32'd39200,
        32'd41530, 32'd44000, 32'd46616, 32'd49388
    };

    // Nominal period in clock cycles, rounded to nearest; octave 1 doubles the frequency
    function automatic longint unsigned period_of(input longint unsigned clk_hz,
                                                  input note_idx_t idx,
                                                  input logic octave);
        longint unsigned f_chz;
        f_chz = 64'(BASE_CHZ[idx]) << octave;
        return (clk_hz * 64'd100 + (f_chz >> 1)) / f_chz;
    endfunction

    // Semitone -> piano key code; flats are reported against the natural above
    function automatic key_code_t key_code_of(input note_idx_t semi);
        key_code_t kc;
        case (semi)
            4'd0:    kc = '{sel: 7'b0000001, flat: 1'b0};  // C
            4'd1:    kc = '{sel: 7'b0000010, flat: 1'b1};  // Db
            4'd2:    kc = '{sel: 7'b0000010, flat: 1'b0};  // D
            4'd3:    kc = '{sel: 7'b0000100, flat: 1'b1};  // Eb
            4'd4:    kc = '{sel: 7'b0000100, flat: 1'b0};  // E
            4'd5:    kc = '{sel: 7'b0001000, flat: 1'b0};  // F
            4'd6:    kc = '{sel: 7'b0010000, flat: 1'b1};  // Gb
            4'd7:    kc = '{sel: 7'b0010000, flat: 1'b0};  // G
            4'd8:    kc = '{sel: 7'b0100000, flat: 1'b1};  // Ab
            4'd9:    kc = '{sel: 7'b0100000, flat: 1'b0};  // A
            4'd10:   kc = '{sel: 7'b1000000, flat: 1'b1};  // Bb
            4'd11:   kc = '{sel: 7'b1000000, flat: 1'b0};  // B
            default: kc = '{sel: 7'b0000000, flat: 1'b0};
        endcase
        return kc;
    endfunction

endpackage

// File: rtl/tone_period_match.sv
// Combinational 24-window period comparator. Each window is the table period
// +/- (period >> TOL_SHIFT), inclusive. If windows overlap, the lowest index wins.
module tone_period_match
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned TOL_SHIFT = 6
) (
    input  logic [CNT_W-1:0]     period,
    output logic                 hit,
    output logic [WIN_IDX_W-1:0] idx
);

    logic [NUM_WIN-1:0] in_win_s;
    logic [63:0]        period_w_s;

    assign period_w_s = 64'(period);

    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
        localparam longint unsigned P  = period_of(64'(CLK_HZ),
                                                   note_idx_t'(gi % NOTES_PER_OCT),
                                                   1'(gi / NOTES_PER_OCT));
        localparam longint unsigned LO = P - (P >> TOL_SHIFT);
        localparam longint unsigned HI = P + (P >> TOL_SHIFT);
        assign in_win_s[gi] = (period_w_s >= LO) && (period_w_s <= HI);
    end

    // Priority encode: scan downward so the lowest matching index is kept
    always_comb begin
        hit = 1'b0;
        idx = {WIN_IDX_W{1'b0}};
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            hit = in_win_s[i] ? 1'b1 : hit;
            idx = in_win_s[i] ? WIN_IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square wave on tone_in and decodes
// it to the piano key/flat/octave code (C4..B5).
// Optional feature macro: TONE_DEC_PERIOD_OUT_EN adds period_out, the last
// measured period (updated on every rising edge). Decoding is unaffected.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned TOL_SHIFT = 6,
    parameter int unsigned STABLE_N  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic             note_valid,
    output logic [6:0]       note_sel,
    output logic             note_flat,
    output logic             note_octave,
    output logic             note_change
`ifdef TONE_DEC_PERIOD_OUT_EN
    ,
    output logic [CNT_W-1:0] period_out
`endif
);

    // Counter saturates at two C4 periods; reaching it means the tone has stopped
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(64'd2 * period_of(64'(CLK_HZ), 4'd0, 1'b0));
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int unsigned      SC_W    = $clog2(STABLE_N + 1);
    localparam logic [SC_W-1:0]  SC_ZERO = {SC_W{1'b0}};
    localparam logic [SC_W-1:0]  SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]  SC_DONE = SC_W'(STABLE_N);

    logic                 sync1_r, sync2_r, sync3_r;
    logic                 rise_s, at_limit_s, timeout_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 hit_s;
    logic [WIN_IDX_W-1:0] idx_s;
    logic                 oct_s;
    note_idx_t            semi_s;
    key_code_t            key_s;

    dec_state_t           state_r, state_nxt_s;
    logic [WIN_IDX_W-1:0] cand_r, cand_nxt_s;
    logic [SC_W-1:0]      stable_r, stable_nxt_s;
    logic [WIN_IDX_W-1:0] cur_idx_r;
    logic                 commit_s;

    logic                 valid_r, flat_r, octave_r, change_r;
    logic [6:0]           sel_r;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= tone_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise_s     = sync2_r & ~sync3_r;
    assign at_limit_s = (cnt_r == TIMEOUT);
    // An edge arriving on the timeout cycle takes precedence
    assign timeout_s  = at_limit_s & ~rise_s;

    // Period counter: counts cycles since the last edge; restarts at 1 on an
    // edge so its value at the next edge equals the period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (!at_limit_s) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    tone_period_match #(
        .CLK_HZ    (CLK_HZ),
        .CNT_W     (CNT_W),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_match (
        .period (cnt_r),
        .hit    (hit_s),
        .idx    (idx_s)
    );

    assign oct_s  = (idx_s >= 5'd12);
    assign semi_s = oct_s ? note_idx_t'(idx_s - 5'd12) : note_idx_t'(idx_s);
    assign key_s  = key_code_of(semi_s);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; timeout overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nxt_s = rise_s ? ST_ACQUIRE : ST_IDLE;
                ST_ACQUIRE: state_nxt_s = commit_s ? ST_LOCKED : ST_ACQUIRE;
                ST_LOCKED:  state_nxt_s = ST_LOCKED;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: candidate tracking and commit decision on each edge.
    // In LOCKED only a note different from the committed one can build a run.
    always_comb begin
        cand_nxt_s   = cand_r;
        stable_nxt_s = stable_r;
        commit_s     = 1'b0;
        if (timeout_s) begin
            stable_nxt_s = SC_ZERO;
        end else if (rise_s) begin
            case (state_r)
                ST_ACQUIRE, ST_LOCKED: begin
                    if (hit_s && ((state_r == ST_ACQUIRE) || (idx_s != cur_idx_r))) begin
                        if (idx_s == cand_r) begin
                            stable_nxt_s = stable_r + 1'b1;
                        end else begin
                            cand_nxt_s   = idx_s;
                            stable_nxt_s = SC_ONE;
                        end
                    end else begin
                        stable_nxt_s = SC_ZERO;
                    end
                end
                default: stable_nxt_s = SC_ZERO;
            endcase
            if (stable_nxt_s == SC_DONE) begin
                commit_s     = 1'b1;
                stable_nxt_s = SC_ZERO;
            end else begin
                commit_s     = 1'b0;
            end
        end else begin
            stable_nxt_s = stable_r;
        end
    end

    // Candidate, run-length and committed-note bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_r    <= {WIN_IDX_W{1'b0}};
            stable_r  <= SC_ZERO;
            cur_idx_r <= {WIN_IDX_W{1'b0}};
        end else begin
            cand_r    <= cand_nxt_s;
            stable_r  <= stable_nxt_s;
            cur_idx_r <= commit_s ? idx_s : cur_idx_r;
        end
    end

    // Registered note outputs; a timeout only drops valid, the code holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r  <= 1'b0;
            sel_r    <= 7'b0000000;
            flat_r   <= 1'b0;
            octave_r <= 1'b0;
            change_r <= 1'b0;
        end else begin
            change_r <= commit_s;
            if (commit_s) begin
                valid_r  <= 1'b1;
                sel_r    <= key_s.sel;
                flat_r   <= key_s.flat;
                octave_r <= oct_s;
            end else if (timeout_s) begin
                valid_r  <= 1'b0;
            end else begin
                valid_r  <= valid_r;
            end
        end
    end

    assign note_valid  = valid_r;
    assign note_sel    = sel_r;
    assign note_flat   = flat_r;
    assign note_octave = octave_r;
    assign note_change = change_r;

`ifdef TONE_DEC_PERIOD_OUT_EN
    logic [CNT_W-1:0] period_r;

    // Last measured period, captured on every rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            period_r <= cnt_r;
        end else begin
            period_r <= period_r;
        end
    end

    assign period_out = period_r;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Directed testbench for tone_decoder at CLK_HZ = 1 MHz.
// Periods: A4 2273, Bb4 2145, C5 1911, A5 1136, off-table 3311; timeout 7644.
module tb_tone_decoder;

    localparam int CNT_W       = 20;
    localparam int PER_A4      = 2273;
    localparam int PER_BB4     = 2145;
    localparam int PER_C5      = 1911;
    localparam int PER_A5      = 1136;
    localparam int PER_OFF     = 3311;
    localparam int TIMEOUT_CYC = 7644;
    localparam int SYNC_LAT    = 3;

    logic       clk;
    logic       rst;
    logic       tone_in;
    logic       note_valid;
    logic [6:0] note_sel;
    logic       note_flat;
    logic       note_octave;
    logic       note_change;
`ifdef TONE_DEC_PERIOD_OUT_EN
    logic [CNT_W-1:0] period_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int change_cnt = 0;

    tone_decoder #(
        .CLK_HZ    (1_000_000),
        .CNT_W     (CNT_W),
        .TOL_SHIFT (6),
        .STABLE_N  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .note_valid  (note_valid),
        .note_sel    (note_sel),
        .note_flat   (note_flat),
        .note_octave (note_octave),
        .note_change (note_change)
`ifdef TONE_DEC_PERIOD_OUT_EN
        ,
        .period_out  (period_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count change pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (note_change === 1'b1) change_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // n full periods of 'per' cycles, each starting with a rising edge; starts and ends on a negedge
    task automatic tone(input int per, input int n);
        for (int k = 0; k < n; k++) begin
            tone_in = 1'b1;
            repeat (per / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (per - per / 2) @(negedge clk);
        end
    endtask

    task automatic check_note(input string tag, input logic v, input logic [6:0] s,
                              input logic f, input logic o);
        check({tag, "_valid"}, 32'(note_valid), 32'(v));
        check({tag, "_sel"},   32'(note_sel),   32'(s));
        check({tag, "_flat"},  32'(note_flat),  32'(f));
        check({tag, "_oct"},   32'(note_octave), 32'(o));
    endtask

    initial begin
        rst     = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        check_note("reset", 1'b0, 7'b0000000, 1'b0, 1'b0);
        check("reset_change", 32'(note_change), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Off-table period between D4 and Eb4 windows: never locks
        tone(PER_OFF, 2);
        check("off_table_valid", 32'(note_valid), 32'd0);

        // A4: the 4th A4 edge measures the 3rd A4 period and commits
        tone(PER_A4, 3);
        check("a4_pre_lock", 32'(note_valid), 32'd0);
        tone(PER_A4, 1);
        check_note("a4_lock", 1'b1, 7'b0100000, 1'b0, 1'b0);
        check("a4_change_cnt", 32'(change_cnt), 32'd1);

        // Bb4: first edge measures the last A4 period, commit on the 4th call
        tone(PER_BB4, 3);
        check_note("bb4_hold", 1'b1, 7'b0100000, 1'b0, 1'b0);
        check("bb4_hold_cnt", 32'(change_cnt), 32'd1);
        tone(PER_BB4, 1);
        check_note("bb4_lock", 1'b1, 7'b1000000, 1'b1, 1'b0);
        check("bb4_change_cnt", 32'(change_cnt), 32'd2);

        // A5
        tone(PER_A5, 4);
        check_note("a5_lock", 1'b1, 7'b0100000, 1'b0, 1'b1);
        check("a5_change_cnt", 32'(change_cnt), 32'd3);

        // Off-table periods inside a lock: outputs hold
        tone(PER_OFF, 2);
        check_note("off_in_lock", 1'b1, 7'b0100000, 1'b0, 1'b1);
        check("off_in_lock_cnt", 32'(change_cnt), 32'd3);

        // Input stops high: valid drops TIMEOUT cycles after the synchronised edge
        tone_in = 1'b1;
        repeat (TIMEOUT_CYC + SYNC_LAT - 1) @(posedge clk);
        #1;
        check("timeout_before", 32'(note_valid), 32'd1);
        @(posedge clk);
        #1;
        check("timeout_at", 32'(note_valid), 32'd0);
        check_note("timeout_hold", 1'b0, 7'b0100000, 1'b0, 1'b1);
        @(negedge clk);
        tone_in = 1'b0;
        @(negedge clk);

        // From IDLE: A4 A4 C5 C5 never reaches three in a row
        tone(PER_A4, 2);
        tone(PER_C5, 2);
        check("alt_acq_valid", 32'(note_valid), 32'd0);
        check("alt_acq_cnt", 32'(change_cnt), 32'd3);
        tone(PER_A4, 3);
        check("a4_relock_pre", 32'(note_valid), 32'd0);
        tone(PER_A4, 1);
        check_note("a4_relock", 1'b1, 7'b0100000, 1'b0, 1'b0);
        check("a4_relock_cnt", 32'(change_cnt), 32'd4);

        // Alternating while LOCKED on A4: no change
        tone(PER_C5, 2);
        tone(PER_A4, 2);
        check_note("alt_lock", 1'b1, 7'b0100000, 1'b0, 1'b0);
        check("alt_lock_cnt", 32'(change_cnt), 32'd4);

        // Asynchronous reset while locked: outputs clear immediately
        rst = 1'b0;
        #1;
        check_note("mid_reset", 1'b0, 7'b0000000, 1'b0, 1'b0);
        check("mid_reset_change", 32'(note_change), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tone(PER_A5, 3);
        check("post_reset_pre", 32'(note_valid), 32'd0);
        check("post_reset_cnt", 32'(change_cnt), 32'd4);
        tone(PER_A5, 1);
        check_note("post_reset_lock", 1'b1, 7'b0100000, 1'b0, 1'b1);
        check("post_reset_lock_cnt", 32'(change_cnt), 32'd5);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
